// File: rtl/apb_ic_master_sched.sv
// ---------------------------------------------------------------------------
// apb_ic_master_sched
//
// Purpose:
//   Shares one downstream APB bus between NUM_MASTERS upstream APB
//   requesters (the per-core master ports of a vmicro16 cluster) and feeds
//   the APB interconnect slave decoder. Arbitration is round-robin at
//   transaction granularity. The granted master keeps the bus until its
//   transfer completes, and nothing preempts it. The block regenerates the
//   SETUP/ACCESS phases downstream and returns PREADY only to the owner.
//
//   Every transfer takes IDLE -> SETUP -> ACCESS(+wait states) -> IDLE.
//   The IDLE cycle is mandatory between transfers, so back-to-back
//   transfers take at least 3 cycles each.
//
// Optional feature:
//   APB_SCHED_TIMEOUT_EN - adds an ACCESS-phase watchdog. After
//   TIMEOUT_CYCLES ACCESS cycles without M_PREADY, the owner sees a forced
//   completion: S_PREADY = 1, S_PSLVERR = 1 and S_PRDATA = 0. When the
//   macro is undefined there is no counter and S_PSLVERR is tied to 0.
//
// Ports:
//   clk, reset      - system clock, synchronous active-high reset
//   S_PSELx         - per-master request (PSEL)
//   S_PADDR         - per-master address, master i in slice i
//   S_PWRITE        - per-master write flag
//   S_PWDATA        - per-master write data, master i in slice i
//   S_PRDATA        - read data broadcast to all masters
//   S_PREADY        - per-master completion strobe (owner bit only)
//   S_PSLVERR       - per-master error strobe (watchdog only)
//   M_PSELx ..      - downstream APB master signals
//   M_PRDATA        - downstream read data
//   M_PREADY        - downstream ready
//   grants          - one-hot current or last bus owner
// ---------------------------------------------------------------------------
module apb_ic_master_sched #(
    parameter int NUM_MASTERS    = 4,
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          reset,

    input  logic [NUM_MASTERS-1:0]        S_PSELx,
    input  logic [NUM_MASTERS*ADDR_W-1:0] S_PADDR,
    input  logic [NUM_MASTERS-1:0]        S_PWRITE,
    input  logic [NUM_MASTERS*DATA_W-1:0] S_PWDATA,
    output logic [DATA_W-1:0]             S_PRDATA,
    output logic [NUM_MASTERS-1:0]        S_PREADY,
    output logic [NUM_MASTERS-1:0]        S_PSLVERR,

    output logic                          M_PSELx,
    output logic                          M_PENABLE,
    output logic [ADDR_W-1:0]             M_PADDR,
    output logic                          M_PWRITE,
    output logic [DATA_W-1:0]             M_PWDATA,
    input  logic [DATA_W-1:0]             M_PRDATA,
    input  logic                          M_PREADY,

    output logic [NUM_MASTERS-1:0]        grants
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    // Elaboration-time parameter sanity checks.
    if (NUM_MASTERS < 2 || NUM_MASTERS > 8) begin : g_bad_num_masters
        $error("apb_ic_master_sched: NUM_MASTERS must be 2..8");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("apb_ic_master_sched: TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t                 state_q;
    logic [NUM_MASTERS-1:0] grants_q;
    logic [IDX_W-1:0]       owner_q;     // binary index of grants_q
    logic                   psel_q;
    logic                   penable_q;
    logic [ADDR_W-1:0]      paddr_q;
    logic                   pwrite_q;
    logic [DATA_W-1:0]      pwdata_q;

    // Per-master views of the flattened request buses.
    logic [ADDR_W-1:0] s_paddr_a  [NUM_MASTERS];
    logic [DATA_W-1:0] s_pwdata_a [NUM_MASTERS];

    for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
        assign s_paddr_a[g]  = S_PADDR[g*ADDR_W +: ADDR_W];
        assign s_pwdata_a[g] = S_PWDATA[g*DATA_W +: DATA_W];
    end

    // -----------------------------------------------------------------------
    // Round-robin winner search. The search starts at the master after the
    // current owner and wraps, so the master just served is checked last.
    // The owner itself is still a candidate when it is the only requester.
    // -----------------------------------------------------------------------
    logic                   win_valid;
    logic [IDX_W-1:0]       win_idx;
    logic [IDX_W:0]         cand_sum;
    logic [NUM_MASTERS-1:0] grants_d;

    // NOTE: every signal gets a default at the top of always_comb, so no
    // path through the block leaves it unassigned and infers a latch.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = owner_q;
        cand_sum  = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            cand_sum = {1'b0, owner_q} + (IDX_W+1)'(i);
            if (cand_sum >= (IDX_W+1)'(NUM_MASTERS)) begin
                cand_sum = cand_sum - (IDX_W+1)'(NUM_MASTERS);
            end
            if (!win_valid && S_PSELx[cand_sum[IDX_W-1:0]]) begin
                win_valid = 1'b1;
                win_idx   = cand_sum[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        grants_d          = '0;
        grants_d[win_idx] = 1'b1;
    end

    // -----------------------------------------------------------------------
    // Optional ACCESS-phase watchdog
    // -----------------------------------------------------------------------
    logic timeout_hit;

`ifdef APB_SCHED_TIMEOUT_EN
    localparam int WD_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                          $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [WD_W-1:0] wdog_q;

    // wdog_q holds the number of ACCESS cycles already completed, so the
    // current cycle is ACCESS cycle wdog_q+1. The watchdog fires on cycle
    // number TIMEOUT_CYCLES. A ready slave takes priority over the watchdog.
    assign timeout_hit = (state_q == ST_ACCESS) && !M_PREADY &&
                         (wdog_q == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            wdog_q <= '0;
        end else if (state_q == ST_IDLE && win_valid) begin
            wdog_q <= '0;
        end else if (state_q == ST_ACCESS) begin
            wdog_q <= wdog_q + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Scheduler FSM with registered downstream controls
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then samples pre-edge values, whatever the statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            grants_q  <= {{(NUM_MASTERS-1){1'b0}}, 1'b1};
            owner_q   <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            // NOTE: the address/data latches are reset too. They are
            // plain registers and not a memory, and clearing them keeps
            // the downstream bus free of X after reset.
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // With no request, grants keeps the last owner. That
                    // owner is the base for the next round-robin search.
                    if (win_valid) begin
                        state_q   <= ST_SETUP;
                        grants_q  <= grants_d;
                        owner_q   <= win_idx;
                        paddr_q   <= s_paddr_a[win_idx];
                        pwrite_q  <= S_PWRITE[win_idx];
                        pwdata_q  <= s_pwdata_a[win_idx];
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                    end
                end

                ST_SETUP: begin
                    state_q   <= ST_ACCESS;
                    penable_q <= 1'b1;
                end

                ST_ACCESS: begin
                    // The owner's S_PSELx is not checked here. A master
                    // that drops PSEL mid-transfer still gets completion.
                    if (M_PREADY || timeout_hit) begin
                        state_q   <= ST_IDLE;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                    end
                end

                default: begin
                    state_q   <= ST_IDLE;
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Upstream completion. It is combinational in the ACCESS cycle where
    // the slave is ready or the watchdog fires. Reset masks it, so an
    // aborted transfer never produces a PREADY pulse.
    // -----------------------------------------------------------------------
    logic xfer_done;
    logic xfer_err;

    assign xfer_done = (state_q == ST_ACCESS) && !reset &&
                       (M_PREADY || timeout_hit);
    assign xfer_err  = xfer_done && timeout_hit;

    assign S_PREADY  = xfer_done ? grants_q : '0;
`ifdef APB_SCHED_TIMEOUT_EN
    assign S_PSLVERR = xfer_err ? grants_q : '0;
`else
    assign S_PSLVERR = '0;
`endif
    // Broadcast read data. Masters qualify it with their own S_PREADY bit.
    assign S_PRDATA  = xfer_err ? '0 : M_PRDATA;

    // -----------------------------------------------------------------------
    // Downstream bus
    // -----------------------------------------------------------------------
    assign M_PSELx   = psel_q;
    assign M_PENABLE = penable_q;
    assign M_PADDR   = paddr_q;
    assign M_PWRITE  = pwrite_q;
    assign M_PWDATA  = pwdata_q;
    assign grants    = grants_q;

endmodule

// File: tb/tb_apb_ic_master_sched.sv
// ---------------------------------------------------------------------------
// tb_apb_ic_master_sched
//
// Directed testbench for apb_ic_master_sched with 4 masters and 16-bit
// address and data. Each scenario task drives the inputs just after a
// rising edge and checks the outputs 1 ns later, well away from the edge.
// ---------------------------------------------------------------------------
module tb_apb_ic_master_sched;

    localparam int NM = 4;
    localparam int AW = 16;
    localparam int DW = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [NM-1:0]    s_psel;
    logic [NM*AW-1:0] s_paddr;
    logic [NM-1:0]    s_pwrite;
    logic [NM*DW-1:0] s_pwdata;
    logic [DW-1:0]    s_prdata;
    logic [NM-1:0]    s_pready;
    logic [NM-1:0]    s_pslverr;
    logic             m_psel;
    logic             m_penable;
    logic [AW-1:0]    m_paddr;
    logic             m_pwrite;
    logic [DW-1:0]    m_pwdata;
    logic [DW-1:0]    m_prdata;
    logic             m_pready;
    logic [NM-1:0]    grants;

    int total = 0;
    int bad   = 0;

    apb_ic_master_sched #(
        .NUM_MASTERS   (NM),
        .ADDR_W        (AW),
        .DATA_W        (DW),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .S_PSELx  (s_psel),
        .S_PADDR  (s_paddr),
        .S_PWRITE (s_pwrite),
        .S_PWDATA (s_pwdata),
        .S_PRDATA (s_prdata),
        .S_PREADY (s_pready),
        .S_PSLVERR(s_pslverr),
        .M_PSELx  (m_psel),
        .M_PENABLE(m_penable),
        .M_PADDR  (m_paddr),
        .M_PWRITE (m_pwrite),
        .M_PWDATA (m_pwdata),
        .M_PRDATA (m_prdata),
        .M_PREADY (m_pready),
        .grants   (grants)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        s_psel = '0; s_paddr = '0; s_pwrite = '0; s_pwdata = '0;
        m_prdata = '0; m_pready = 1'b0;
        repeat (5) tick();
        total++; if (grants !== 4'b0001) begin bad++; $display("FAIL reset_grants: got %b want 0001", grants); end
        total++; if (m_psel !== 1'b0 || m_penable !== 1'b0) begin bad++; $display("FAIL reset_psel_pen: got %b%b want 00", m_psel, m_penable); end
        total++; if (s_pready !== 4'b0000 || s_pslverr !== 4'b0000) begin bad++; $display("FAIL reset_pready_pslverr: got %b/%b want 0000/0000", s_pready, s_pslverr); end
        reset = 1'b0;
        repeat (3) tick();
        total++; if (grants !== 4'b0001 || m_psel !== 1'b0) begin bad++; $display("FAIL idle_hold: got grants=%b psel=%b want 0001/0", grants, m_psel); end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_single_read();
        s_psel = 4'b0010;
        s_paddr[31:16] = 16'h0040;
        s_pwrite = 4'b0000;
        m_pready = 1'b1;
        m_prdata = 16'hBEEF;
        tick(); // SETUP
        total++; if (grants !== 4'b0010) begin bad++; $display("FAIL read_grants: got %b want 0010", grants); end
        total++; if ({m_psel, m_penable} !== 2'b10) begin bad++; $display("FAIL read_setup_phase: got %b%b want 10", m_psel, m_penable); end
        total++; if (m_paddr !== 16'h0040 || m_pwrite !== 1'b0) begin bad++; $display("FAIL read_addr: got %h/%b want 0040/0", m_paddr, m_pwrite); end
        total++; if (s_pready !== 4'b0000) begin bad++; $display("FAIL read_setup_pready: got %b want 0000", s_pready); end
        tick(); // ACCESS, zero wait
        total++; if ({m_psel, m_penable} !== 2'b11) begin bad++; $display("FAIL read_access_phase: got %b%b want 11", m_psel, m_penable); end
        total++; if (s_pready !== 4'b0010) begin bad++; $display("FAIL read_pready: got %b want 0010", s_pready); end
        total++; if (s_prdata !== 16'hBEEF) begin bad++; $display("FAIL read_prdata: got %h want beef", s_prdata); end
        tick(); // IDLE
        s_psel = 4'b0000;
        total++; if (m_psel !== 1'b0 || s_pready !== 4'b0000 || grants !== 4'b0010) begin bad++; $display("FAIL read_idle: got psel=%b pready=%b grants=%b want 0/0000/0010", m_psel, s_pready, grants); end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_contention();
        logic [NM-1:0] exp_g [4];
        logic [AW-1:0] exp_a [4];
        exp_g = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_a = '{16'hA001, 16'hA002, 16'hA003, 16'hA000};
        reset = 1'b1;
        tick();
        reset = 1'b0;
        s_paddr  = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
        s_psel   = 4'b1111;
        m_pready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            m_prdata = 16'hC000 + 16'(k);
            tick(); // SETUP
            total++; if (grants !== exp_g[k] || m_paddr !== exp_a[k]) begin bad++; $display("FAIL rr_setup[%0d]: got grants=%b addr=%h want %b/%h", k, grants, m_paddr, exp_g[k], exp_a[k]); end
            tick(); // ACCESS
            total++; if (s_pready !== exp_g[k] || s_prdata !== 16'hC000 + 16'(k)) begin bad++; $display("FAIL rr_pready[%0d]: got %b/%h want %b/%h", k, s_pready, s_prdata, exp_g[k], 16'hC000 + 16'(k)); end
            tick(); // mandatory IDLE
            total++; if (m_psel !== 1'b0 || s_pready !== 4'b0000) begin bad++; $display("FAIL rr_turnaround[%0d]: got psel=%b pready=%b want 0/0000", k, m_psel, s_pready); end
        end
        s_psel = 4'b0000;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_wait_states();
        s_psel = 4'b0100;
        s_paddr[47:32]  = 16'h0100;
        s_pwrite        = 4'b0100;
        s_pwdata[47:32] = 16'h1234;
        m_pready = 1'b0;
        tick(); // SETUP
        total++; if (grants !== 4'b0100 || m_paddr !== 16'h0100 || m_pwrite !== 1'b1 || m_pwdata !== 16'h1234) begin bad++; $display("FAIL ws_setup: got %b/%h/%b/%h want 0100/0100/1/1234", grants, m_paddr, m_pwrite, m_pwdata); end
        s_psel = 4'b1100; // master 3 queues up behind master 2
        for (int c = 0; c < 4; c++) begin
            tick();
            total++; if (m_penable !== 1'b1 || m_pwdata !== 16'h1234 || s_pready !== 4'b0000 || grants !== 4'b0100) begin bad++; $display("FAIL ws_wait[%0d]: got pen=%b wdata=%h pready=%b grants=%b want 1/1234/0000/0100", c, m_penable, m_pwdata, s_pready, grants); end
        end
        tick(); // fifth ACCESS cycle, slave ready
        m_pready = 1'b1;
        #1;
        total++; if (s_pready !== 4'b0100) begin bad++; $display("FAIL ws_pready: got %b want 0100", s_pready); end
        tick(); // IDLE
        s_psel = 4'b1000;
        total++; if (m_psel !== 1'b0 || grants !== 4'b0100) begin bad++; $display("FAIL ws_idle: got psel=%b grants=%b want 0/0100", m_psel, grants); end
        tick(); // SETUP for master 3
        total++; if (grants !== 4'b1000) begin bad++; $display("FAIL ws_next_grant: got %b want 1000", grants); end
        tick(); // ACCESS
        total++; if (s_pready !== 4'b1000 || s_pslverr !== 4'b0000) begin bad++; $display("FAIL ws_next_pready: got %b/%b want 1000/0000", s_pready, s_pslverr); end
        tick();
        s_psel = 4'b0000;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_owner_drop();
        s_psel = 4'b0001;
        s_pwrite = 4'b0000;
        tick(); // SETUP, owner wraps from 3 to 0
        total++; if (grants !== 4'b0001) begin bad++; $display("FAIL drop_grant: got %b want 0001", grants); end
        s_psel = 4'b0000; // protocol violation
        m_pready = 1'b1;
        tick(); // ACCESS
        total++; if (s_pready !== 4'b0001 || m_penable !== 1'b1) begin bad++; $display("FAIL drop_pready: got %b/%b want 0001/1", s_pready, m_penable); end
        tick();
        total++; if (m_psel !== 1'b0 || grants !== 4'b0001) begin bad++; $display("FAIL drop_idle: got %b/%b want 0/0001", m_psel, grants); end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_back_to_back();
        s_psel = 4'b0010;
        m_pready = 1'b1;
        tick(); // SETUP
        tick(); // ACCESS, master 3 raises its request in the completion cycle
        s_psel = 4'b1010;
        #1;
        total++; if (s_pready !== 4'b0010 || m_psel !== 1'b1) begin bad++; $display("FAIL b2b_first: got %b/%b want 0010/1", s_pready, m_psel); end
        tick(); // IDLE, the new request has not been granted yet
        s_psel = 4'b1000;
        total++; if (m_psel !== 1'b0 || grants !== 4'b0010) begin bad++; $display("FAIL b2b_turnaround: got %b/%b want 0/0010", m_psel, grants); end
        tick(); // SETUP
        total++; if (grants !== 4'b1000 || m_psel !== 1'b1) begin bad++; $display("FAIL b2b_second_grant: got %b/%b want 1000/1", grants, m_psel); end
        tick(); // ACCESS
        total++; if (s_pready !== 4'b1000) begin bad++; $display("FAIL b2b_second_pready: got %b want 1000", s_pready); end
        tick();
        s_psel = 4'b0000;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset_mid_transfer();
        s_psel = 4'b0100;
        m_pready = 1'b0;
        tick(); // SETUP
        total++; if (grants !== 4'b0100) begin bad++; $display("FAIL rst_mid_grant: got %b want 0100", grants); end
        tick(); // ACCESS
        reset = 1'b1;
        m_pready = 1'b1;
        #1;
        total++; if (s_pready !== 4'b0000) begin bad++; $display("FAIL rst_mid_no_pready: got %b want 0000", s_pready); end
        tick();
        total++; if (m_psel !== 1'b0 || m_penable !== 1'b0 || grants !== 4'b0001 || s_pready !== 4'b0000) begin bad++; $display("FAIL rst_mid_state: got %b%b/%b/%b want 00/0001/0000", m_psel, m_penable, grants, s_pready); end
        reset = 1'b0;
        s_psel = 4'b0000;
        m_pready = 1'b0;
        tick();
        total++; if (m_psel !== 1'b0 || s_pready !== 4'b0000) begin bad++; $display("FAIL rst_mid_after: got %b/%b want 0/0000", m_psel, s_pready); end
    endtask

    // -----------------------------------------------------------------------
`ifdef APB_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        s_psel = 4'b0010;
        m_pready = 1'b0;
        m_prdata = 16'hFFFF;
        tick(); // SETUP
        for (int c = 1; c < 8; c++) begin
            tick();
            total++; if (s_pready !== 4'b0000 || s_pslverr !== 4'b0000) begin bad++; $display("FAIL to_wait[%0d]: got %b/%b want 0000/0000", c, s_pready, s_pslverr); end
        end
        tick(); // eighth ACCESS cycle
        total++; if (s_pready !== 4'b0010 || s_pslverr !== 4'b0010 || s_prdata !== 16'h0000) begin bad++; $display("FAIL to_fire: got %b/%b/%h want 0010/0010/0000", s_pready, s_pslverr, s_prdata); end
        tick();
        s_psel = 4'b0000;
        total++; if (m_psel !== 1'b0 || s_pslverr !== 4'b0000) begin bad++; $display("FAIL to_idle: got %b/%b want 0/0000", m_psel, s_pslverr); end
        // Ready on the same cycle as the timeout: normal completion wins.
        s_psel = 4'b0100;
        tick(); // SETUP
        repeat (7) tick();
        tick(); // eighth ACCESS cycle
        m_pready = 1'b1;
        #1;
        total++; if (s_pready !== 4'b0100 || s_pslverr !== 4'b0000 || s_prdata !== 16'hFFFF) begin bad++; $display("FAIL to_tie: got %b/%b/%h want 0100/0000/ffff", s_pready, s_pslverr, s_prdata); end
        tick();
        s_psel = 4'b0000;
        m_pready = 1'b0;
    endtask
`else
    task automatic test_no_timeout();
        s_psel = 4'b0010;
        m_pready = 1'b0;
        tick(); // SETUP
        repeat (20) tick();
        total++; if (s_pready !== 4'b0000 || s_pslverr !== 4'b0000 || m_penable !== 1'b1) begin bad++; $display("FAIL nto_stall: got %b/%b/%b want 0000/0000/1", s_pready, s_pslverr, m_penable); end
        m_pready = 1'b1;
        #1;
        total++; if (s_pready !== 4'b0010 || s_pslverr !== 4'b0000) begin bad++; $display("FAIL nto_done: got %b/%b want 0010/0000", s_pready, s_pslverr); end
        tick();
        s_psel = 4'b0000;
        m_pready = 1'b0;
    endtask
`endif

    // -----------------------------------------------------------------------
    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_wait_states();
        test_owner_drop();
        test_back_to_back();
        test_reset_mid_transfer();
`ifdef APB_SCHED_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_ic_master_sched.md
Name: apb_ic_master_sched

Overview:
Shares a single downstream APB bus between NUM_MASTERS upstream APB requesters (the vmicro16 cores in the cluster).
- Round-robin arbitration at transaction granularity.
- Once granted, a master owns the bus until its transfer completes; no preemption.
- Regenerates the APB SETUP/ACCESS phases downstream and returns PREADY/PRDATA to the granted master only.
- Sits between the per-core APB master ports and the APB interconnect slave decoder.

Parameters:
- NUM_MASTERS, 4, number of upstream requesters (2..8).
- ADDR_W, 16, APB address width.
- DATA_W, 16, APB data width.
- TIMEOUT_CYCLES, 255, watchdog limit in ACCESS (used only with APB_SCHED_TIMEOUT_EN).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- S_PSELx  in  NUM_MASTERS  per-master request (APB PSEL).
- S_PADDR  in  NUM_MASTERS*ADDR_W  per-master address; master i occupies slice i.
- S_PWRITE  in  NUM_MASTERS  per-master write flag.
- S_PWDATA  in  NUM_MASTERS*DATA_W  per-master write data.
- S_PRDATA  out  DATA_W  read data, broadcast to all masters.
- S_PREADY  out  NUM_MASTERS  per-master completion strobe.
- S_PSLVERR  out  NUM_MASTERS  per-master error strobe.
- M_PSELx  out  1  downstream select.
- M_PENABLE  out  1  downstream enable.
- M_PADDR  out  ADDR_W  downstream address.
- M_PWRITE  out  1  downstream write flag.
- M_PWDATA  out  DATA_W  downstream write data.
- M_PRDATA  in  DATA_W  downstream read data.
- M_PREADY  in  1  downstream ready.
- grants  out  NUM_MASTERS  one-hot current owner.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values:
  - state = IDLE.
  - grants = 1 (master 0, matching the existing arbiter convention).
  - M_PSELx = 0, M_PENABLE = 0.
  - S_PREADY = 0, S_PSLVERR = 0.
  - watchdog = 0.
- Reset mid-transfer: aborts immediately with no S_PREADY pulse. The downstream bus drops PSEL on the next edge.
- FSM IDLE:
  - Wait for any S_PSELx bit.
  - Select the winner by round-robin search starting at the bit after the current grants owner, wrapping modulo NUM_MASTERS.
  - Register the winner into grants and latch its PADDR, PWRITE and PWDATA into downstream registers.
  - Go to SETUP.
  - With no request, grants holds its last value.
- FSM SETUP (exactly 1 cycle): M_PSELx = 1, M_PENABLE = 0, latched address and data driven. Go to ACCESS.
- FSM ACCESS:
  - M_PSELx = 1, M_PENABLE = 1.
  - Hold until M_PREADY = 1.
  - In the M_PREADY cycle: S_PREADY[owner] = M_PREADY (combinational, only that bit) and S_PRDATA = M_PRDATA.
  - Next state is IDLE.
- Latency: request seen in cycle n → SETUP at n+1 → ACCESS at n+2 → earliest S_PREADY at n+2 (zero-wait-state slave).
- Turnaround: a mandatory IDLE cycle between transfers. Back-to-back transfers take a minimum of 3 cycles each.
- Fairness: the master just served has lowest priority next arbitration. With all masters requesting, the grant order is 1, 2, 3, 0, 1, …
- Simultaneous events: a request arriving in the same cycle another completes is considered in the following IDLE cycle.
- Owner drops S_PSELx mid-transfer (protocol violation): the downstream transfer still completes and S_PREADY is still pulsed.
- Non-granted masters: see S_PREADY = 0 and stall. S_PRDATA may carry other masters' data; masters qualify it with their own S_PREADY bit.
- Downstream outputs outside SETUP/ACCESS: M_PSELx = 0, M_PENABLE = 0. Address and data hold their last latched values.

Optional Feature:
APB_SCHED_TIMEOUT_EN
- Defined:
  - An 8-bit+ watchdog counts cycles in ACCESS; it is cleared on entering SETUP.
  - When the count reaches TIMEOUT_CYCLES without M_PREADY, force completion in that cycle: S_PREADY[owner] = 1, S_PSLVERR[owner] = 1, S_PRDATA = 0. Return to IDLE.
  - M_PREADY arriving in the same cycle as the timeout wins: normal completion, no error.
- Undefined: no counter; ACCESS waits indefinitely; S_PSLVERR is tied to 0.

Test Plan:
- Reset held 5 cycles with S_PSELx = 0000 → grants = 0001, M_PSELx = 0, S_PREADY = 0000. After release with no requests, grants stays 0001.
- Single read: S_PSELx = 0010, S_PADDR[1] = 16'h0040, slave returns M_PRDATA = 16'hBEEF with zero wait → grants = 0010 at n+1, M_PSELx/M_PENABLE = 10 then 11, S_PREADY = 0010 with S_PRDATA = BEEF at n+2.
- Contention: S_PSELx = 1111 held with grants = 0001 → owners in order 0010, 0100, 1000, 0001; each S_PREADY pulse one-hot on its owner; 3 cycles per transfer.
- Wait states: master 2 writes 16'h1234 to 16'h0100, slave holds M_PREADY = 0 for 4 ACCESS cycles → M_PWDATA = 1234 stable throughout; a new S_PSELx = 1000 is not granted until after S_PREADY = 0100.
- Reset mid-transfer: reset asserted during ACCESS → next cycle state IDLE, M_PSELx = 0, grants = 0001, no S_PREADY pulse.
- (APB_SCHED_TIMEOUT_EN) slave never asserts M_PREADY, TIMEOUT_CYCLES = 8 → S_PREADY[owner] = 1, S_PSLVERR[owner] = 1, S_PRDATA = 0 after 8 ACCESS cycles, then IDLE.
